// File: rtl/axis_ramp_src_if.sv
// AXI-stream video bus carrying the ramp pattern from source to sink.
// tuser: [0] SOF, [1] EOF, [2] SOL, [3] EOL.
interface axis_ramp_src_if;
   logic        aclk_tready;
   logic        aclk_tvalid;
   logic [3:0]  aclk_tuser;
   logic        aclk_tlast;
   logic [63:0] aclk_tdata;

   modport master (input aclk_tready, output aclk_tvalid, aclk_tuser, aclk_tlast, aclk_tdata);
   modport slave  (output aclk_tready, input aclk_tvalid, aclk_tuser, aclk_tlast, aclk_tdata);
endinterface

// File: rtl/axis_ramp_src.sv
// Test-pattern source: one start pulse emits a frame of y lines. Each line
// carries an x-pixel horizontal ramp, with LINE_GAP idle cycles between lines.
module axis_ramp_src #(
   parameter int LINE_GAP = 4
) (
   input  logic                   aclk,
   input  logic                   aclk_reset_n,
   input  logic                   aclk_start,
   input  logic [2:0]             aclk_pixel_width,
   input  logic [12:0]            aclk_x_size,
   input  logic [11:0]            aclk_y_size,
   output logic                   aclk_busy,
   axis_ramp_src_if.master        axis
);
   localparam int GW = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

   typedef enum logic [1:0] {IDLE, LINE, GAP} state_t;

   state_t        state_q, state_d;
   logic          pw2_q, pw2_d;
   logic [12:0]   x_q, x_d;
   logic [11:0]   y_q, y_d;
   logic [15:0]   bpl_q, bpl_d;
   logic [15:0]   beat_q, beat_d;
   logic [11:0]   line_q, line_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          busy_q, busy_d;
   logic          tvalid_q, tvalid_d;
   logic [3:0]    tuser_q, tuser_d;
   logic          tlast_q, tlast_d;
   logic [63:0]   tdata_q, tdata_d;

   logic          start_ok, xfer, last_beat, last_line;
   logic          g_pw2, load;
   logic [12:0]   g_x;
   logic [11:0]   g_y;
   logic [15:0]   g_bpl, g_xbytes;
   logic [15:0]   ld_beat, pix;
   logic [11:0]   ld_line;
   logic [63:0]   gen_data;
   logic [3:0]    gen_user;
   logic          gen_first, gen_last;

   // busy_q still high in IDLE marks the post-EOF cycle where starts are ignored
   assign start_ok  = (state_q == IDLE) && !busy_q && aclk_start &&
                      (aclk_x_size != '0) && (aclk_y_size != '0) &&
                      ((aclk_pixel_width == 3'd1) || (aclk_pixel_width == 3'd2));
   assign xfer      = tvalid_q && axis.aclk_tready;
   assign last_beat = (beat_q == bpl_q - 16'd1);
   assign last_line = (line_q == y_q - 12'd1);

   // In IDLE the beat generator sees the live config so beat 0 loads on start
   assign g_pw2    = (state_q == IDLE) ? (aclk_pixel_width == 3'd2) : pw2_q;
   assign g_x      = (state_q == IDLE) ? aclk_x_size : x_q;
   assign g_y      = (state_q == IDLE) ? aclk_y_size : y_q;
   assign g_xbytes = g_pw2 ? {2'b00, g_x, 1'b0} : {3'b000, g_x};
   assign g_bpl    = (state_q == IDLE) ? ((g_xbytes + 16'd7) >> 3) : bpl_q;

   always_comb begin
      gen_data = '0;
      pix      = '0;
      if (!g_pw2) begin
         for (int j = 0; j < 8; j++) begin
            pix = {ld_beat[12:0], 3'b000} + 16'(j);
            if (pix < {3'b000, g_x}) gen_data[8*j +: 8] = pix[7:0];
         end
      end else begin
         for (int j = 0; j < 4; j++) begin
            pix = {ld_beat[13:0], 2'b00} + 16'(j);
            if (pix < {3'b000, g_x}) gen_data[16*j +: 16] = pix;
         end
      end
   end

   assign gen_first = (ld_beat == '0);
   assign gen_last  = (ld_beat == g_bpl - 16'd1);
   assign gen_user  = {gen_last  && (ld_line != g_y - 12'd1),
                       gen_first && (ld_line != '0),
                       gen_last  && (ld_line == g_y - 12'd1),
                       gen_first && (ld_line == '0)};

   always_comb begin
      state_d  = state_q;
      pw2_d    = pw2_q;
      x_d      = x_q;
      y_d      = y_q;
      bpl_d    = bpl_q;
      beat_d   = beat_q;
      line_d   = line_q;
      gap_d    = gap_q;
      busy_d   = busy_q;
      tvalid_d = tvalid_q;
      tuser_d  = tuser_q;
      tlast_d  = tlast_q;
      tdata_d  = tdata_q;
      load     = 1'b0;
      ld_beat  = beat_q + 16'd1;
      ld_line  = line_q;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start_ok) begin
               pw2_d   = g_pw2;
               x_d     = g_x;
               y_d     = g_y;
               bpl_d   = g_bpl;
               busy_d  = 1'b1;
               load    = 1'b1;
               ld_beat = '0;
               ld_line = '0;
               state_d = LINE;
            end
         end
         LINE: begin
            if (xfer) begin
               if (!last_beat) begin
                  load = 1'b1;
               end else if (last_line) begin
                  state_d = IDLE;
               end else if (LINE_GAP == 0) begin
                  load    = 1'b1;
                  ld_beat = '0;
                  ld_line = line_q + 12'd1;
               end else begin
                  state_d = GAP;
                  gap_d   = '0;
                  line_d  = line_q + 12'd1;
               end
               if (!load) begin
                  tvalid_d = 1'b0;
                  tuser_d  = '0;
                  tlast_d  = 1'b0;
                  tdata_d  = '0;
               end
            end
         end
         GAP: begin
            if (gap_q == GW'(LINE_GAP - 1)) begin
               load    = 1'b1;
               ld_beat = '0;
               state_d = LINE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         beat_d   = ld_beat;
         line_d   = ld_line;
         tvalid_d = 1'b1;
         tdata_d  = gen_data;
         tuser_d  = gen_user;
         tlast_d  = gen_last;
      end
   end

   always_ff @(posedge aclk or negedge aclk_reset_n) begin
      if (!aclk_reset_n) begin
         state_q  <= IDLE;
         pw2_q    <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         bpl_q    <= '0;
         beat_q   <= '0;
         line_q   <= '0;
         gap_q    <= '0;
         busy_q   <= 1'b0;
         tvalid_q <= 1'b0;
         tuser_q  <= '0;
         tlast_q  <= 1'b0;
         tdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         pw2_q    <= pw2_d;
         x_q      <= x_d;
         y_q      <= y_d;
         bpl_q    <= bpl_d;
         beat_q   <= beat_d;
         line_q   <= line_d;
         gap_q    <= gap_d;
         busy_q   <= busy_d;
         tvalid_q <= tvalid_d;
         tuser_q  <= tuser_d;
         tlast_q  <= tlast_d;
         tdata_q  <= tdata_d;
      end
   end

   assign aclk_busy        = busy_q;
   assign axis.aclk_tvalid = tvalid_q;
   assign axis.aclk_tuser  = tuser_q;
   assign axis.aclk_tlast  = tlast_q;
   assign axis.aclk_tdata  = tdata_q;
endmodule

// File: tb/tb_axis_ramp_src.sv
// Directed bench for axis_ramp_src: ramp content, sync flags, gaps, stalls,
// busy timing, ignored starts and mid-frame reset.
module tb_axis_ramp_src;
   logic        aclk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  pw = 3'd1;
   logic [12:0] xs = '0;
   logic [11:0] ys = '0;
   logic        busy;

   axis_ramp_src_if axis();

   axis_ramp_src #(.LINE_GAP(4)) dut (
      .aclk             (aclk),
      .aclk_reset_n     (rst_n),
      .aclk_start       (start),
      .aclk_pixel_width (pw),
      .aclk_x_size      (xs),
      .aclk_y_size      (ys),
      .aclk_busy        (busy),
      .axis             (axis)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;
   logic [63:0] cap_data[$];
   logic [3:0]  cap_user[$];
   logic        cap_last[$];
   int          cap_cyc[$];

   // Returns on the negedge after the start pulse was sampled.
   task automatic start_frame(input logic [2:0] p, input logic [12:0] x, input logic [11:0] y);
      @(negedge aclk);
      pw = p; xs = x; ys = y; start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
   endtask

   // Captures beats until EOF; with stall set, tready drops every 8th cycle
   // and held beats must not change.
   task automatic collect(input bit stall, input int budget);
      logic [63:0] hd;
      logic [3:0]  hu;
      logic        hl;
      bit held = 0;
      bit done = 0;
      cap_data.delete(); cap_user.delete(); cap_last.delete(); cap_cyc.delete();
      hd = '0; hu = '0; hl = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         axis.aclk_tready = !(stall && (c % 8 == 7));
         if (held) begin
            checks++;
            if (axis.aclk_tvalid !== 1'b1 || axis.aclk_tdata !== hd ||
                axis.aclk_tuser !== hu || axis.aclk_tlast !== hl) begin
               errors++;
               $display("FAIL stall_hold cyc %0d: got v=%b d=%h u=%h l=%b, want v=1 d=%h u=%h l=%b",
                        c, axis.aclk_tvalid, axis.aclk_tdata, axis.aclk_tuser, axis.aclk_tlast, hd, hu, hl);
            end
         end
         held = axis.aclk_tvalid && !axis.aclk_tready;
         hd = axis.aclk_tdata; hu = axis.aclk_tuser; hl = axis.aclk_tlast;
         if (axis.aclk_tvalid && axis.aclk_tready) begin
            cap_data.push_back(axis.aclk_tdata);
            cap_user.push_back(axis.aclk_tuser);
            cap_last.push_back(axis.aclk_tlast);
            cap_cyc.push_back(c);
            if (axis.aclk_tuser[1]) done = 1;
         end
         @(negedge aclk);
      end
      axis.aclk_tready = 1'b1;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL collect_timeout: got %0d beats, no EOF within %0d cycles", cap_data.size(), budget);
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (axis.aclk_tvalid !== 1'b0 || axis.aclk_tdata !== 64'd0 || axis.aclk_tuser !== 4'd0 ||
          axis.aclk_tlast !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b d=%h u=%h l=%b busy=%b, want all 0",
                  axis.aclk_tvalid, axis.aclk_tdata, axis.aclk_tuser, axis.aclk_tlast, busy);
      end
      repeat (3) @(negedge aclk);
      rst_n = 1'b1;
      repeat (2) @(negedge aclk);
      checks++;
      if (axis.aclk_tvalid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got v=%b busy=%b, want 0 0", axis.aclk_tvalid, busy);
      end
   endtask

   // pw=1 x=256 y=4: 4 lines x 32 beats; byte j of line beat b is 8b+j.
   task automatic check_ramp_256x4(input bit full_rate);
      logic [63:0] ed;
      logic [3:0]  eu;
      int bi, ln;
      checks++;
      if (cap_data.size() != 128) begin
         errors++;
         $display("FAIL ramp_beat_count: got %0d, want 128", cap_data.size());
      end else begin
         for (int i = 0; i < 128; i++) begin
            bi = i % 32; ln = i / 32;
            for (int j = 0; j < 8; j++) ed[8*j +: 8] = 8'(bi * 8 + j);
            eu = 4'd0;
            if (bi == 0)  eu = (ln == 0) ? 4'h1 : 4'h4;
            if (bi == 31) eu = (ln == 3) ? 4'h2 : 4'h8;
            checks++;
            if (cap_data[i] !== ed || cap_user[i] !== eu || cap_last[i] !== (bi == 31)) begin
               errors++;
               $display("FAIL ramp_beat %0d: got d=%h u=%h l=%b, want d=%h u=%h l=%b",
                        i, cap_data[i], cap_user[i], cap_last[i], ed, eu, bi == 31);
            end
         end
         checks++;
         if (cap_data[0] !== 64'h0706050403020100 || cap_user[0] !== 4'h1 ||
             cap_data[127] !== 64'hFFFEFDFCFBFAF9F8 || cap_user[127] !== 4'h2 || cap_last[127] !== 1'b1) begin
            errors++;
            $display("FAIL ramp_ends: got first %h/%h last %h/%h/%b", cap_data[0], cap_user[0],
                     cap_data[127], cap_user[127], cap_last[127]);
         end
         if (full_rate) begin
            checks++;
            if (cap_cyc[31] - cap_cyc[0] != 31) begin
               errors++;
               $display("FAIL back_to_back: line 0 spans %0d cycles, want 31", cap_cyc[31] - cap_cyc[0]);
            end
            for (int l = 1; l < 4; l++) begin
               checks++;
               if (cap_cyc[l*32] - cap_cyc[l*32-1] - 1 != 4) begin
                  errors++;
                  $display("FAIL line_gap %0d: got %0d idle cycles, want 4", l, cap_cyc[l*32] - cap_cyc[l*32-1] - 1);
               end
            end
         end
      end
   endtask

   task automatic test_full_rate();
      start_frame(3'd1, 13'd256, 12'd4);
      collect(1'b0, 400);
      check_ramp_256x4(1'b1);
   endtask

   task automatic test_stall();
      start_frame(3'd1, 13'd256, 12'd4);
      collect(1'b1, 600);
      check_ramp_256x4(1'b0);
   endtask

   task automatic test_partial_beat();
      logic [63:0] ed[4];
      logic [3:0]  eu[4];
      logic        el[4];
      ed = '{64'h0706050403020100, 64'h0000000C0B0A0908, 64'h0706050403020100, 64'h0000000C0B0A0908};
      eu = '{4'h1, 4'h8, 4'h4, 4'h2};
      el = '{1'b0, 1'b1, 1'b0, 1'b1};
      start_frame(3'd1, 13'd13, 12'd2);
      collect(1'b0, 100);
      checks++;
      if (cap_data.size() != 4) begin
         errors++;
         $display("FAIL partial_count: got %0d, want 4", cap_data.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_data[i] !== ed[i] || cap_user[i] !== eu[i] || cap_last[i] !== el[i]) begin
               errors++;
               $display("FAIL partial_beat %0d: got d=%h u=%h l=%b, want d=%h u=%h l=%b",
                        i, cap_data[i], cap_user[i], cap_last[i], ed[i], eu[i], el[i]);
            end
         end
      end
   endtask

   task automatic test_single_beat();
      int busy_cnt = 0;
      axis.aclk_tready = 1'b1;
      start_frame(3'd2, 13'd4, 12'd1);
      checks++;
      if (axis.aclk_tvalid !== 1'b1 || axis.aclk_tdata !== 64'h0003000200010000 ||
          axis.aclk_tuser !== 4'h3 || axis.aclk_tlast !== 1'b1) begin
         errors++;
         $display("FAIL single_beat: got v=%b d=%h u=%h l=%b, want 1 0003000200010000 3 1",
                  axis.aclk_tvalid, axis.aclk_tdata, axis.aclk_tuser, axis.aclk_tlast);
      end
      if (busy) busy_cnt++;
      @(negedge aclk);
      if (busy) busy_cnt++;
      pw = 3'd1; xs = 13'd13; ys = 12'd1; start = 1'b1;  // lands in the post-EOF cycle
      @(negedge aclk);
      start = 1'b0;
      if (busy) busy_cnt++;
      @(negedge aclk);
      if (busy) busy_cnt++;
      checks++;
      if (busy_cnt != 2) begin
         errors++;
         $display("FAIL single_busy_cycles: got %0d, want 2", busy_cnt);
      end
      checks++;
      if (axis.aclk_tvalid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_eof_start: got v=%b busy=%b, want 0 0", axis.aclk_tvalid, busy);
      end
   endtask

   task automatic test_ignored_start();
      axis.aclk_tready = 1'b0;
      start_frame(3'd1, 13'd13, 12'd1);
      pw = 3'd2; xs = 13'd4; ys = 12'd3; start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      collect(1'b0, 100);
      checks++;
      if (cap_data.size() != 2 || cap_data[0] !== 64'h0706050403020100 || cap_user[0] !== 4'h1 ||
          cap_data[1] !== 64'h0000000C0B0A0908 || cap_user[1] !== 4'h2 || cap_last[1] !== 1'b1) begin
         errors++;
         $display("FAIL start_while_busy: got %0d beats, first %h/%h", cap_data.size(),
                  cap_data.size() > 0 ? cap_data[0] : 64'd0, cap_user.size() > 0 ? cap_user[0] : 4'd0);
      end
      repeat (2) @(negedge aclk);
      start_frame(3'd1, 13'd0, 12'd4);
      repeat (3) @(negedge aclk);
      checks++;
      if (axis.aclk_tvalid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL start_x0: got v=%b busy=%b, want 0 0", axis.aclk_tvalid, busy);
      end
      start_frame(3'd3, 13'd8, 12'd1);
      repeat (3) @(negedge aclk);
      checks++;
      if (axis.aclk_tvalid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL start_pw3: got v=%b busy=%b, want 0 0", axis.aclk_tvalid, busy);
      end
   endtask

   task automatic test_reset_midframe();
      int nb = 0;
      axis.aclk_tready = 1'b1;
      start_frame(3'd1, 13'd256, 12'd4);
      for (int c = 0; c < 500; c++) begin
         if (axis.aclk_tvalid && nb == 42) break;
         if (axis.aclk_tvalid) nb++;
         @(negedge aclk);
      end
      checks++;
      if (nb != 42 || axis.aclk_tvalid !== 1'b1 || axis.aclk_tdata !== 64'h5756555453525150) begin
         errors++;
         $display("FAIL reach_line1_beat10: got nb=%0d v=%b d=%h, want 42 1 5756555453525150",
                  nb, axis.aclk_tvalid, axis.aclk_tdata);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (axis.aclk_tvalid !== 1'b0 || axis.aclk_tdata !== 64'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got v=%b d=%h busy=%b, want 0 0 0", axis.aclk_tvalid, axis.aclk_tdata, busy);
      end
      repeat (2) @(negedge aclk);
      rst_n = 1'b1;
      repeat (3) @(negedge aclk);
      checks++;
      if (axis.aclk_tvalid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle: got v=%b busy=%b, want 0 0", axis.aclk_tvalid, busy);
      end
      start_frame(3'd1, 13'd13, 12'd2);
      collect(1'b0, 100);
      checks++;
      if (cap_data.size() != 4 || cap_user[0] !== 4'h1 || cap_data[0] !== 64'h0706050403020100) begin
         errors++;
         $display("FAIL restart_sof: got %0d beats, first %h/%h, want 4 0706050403020100/1", cap_data.size(),
                  cap_data.size() > 0 ? cap_data[0] : 64'd0, cap_user.size() > 0 ? cap_user[0] : 4'd0);
      end
   endtask

   initial begin
      axis.aclk_tready = 1'b1;
      test_reset();
      test_full_rate();
      test_stall();
      test_partial_beat();
      test_single_beat();
      test_ignored_start();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
